// File: rtl/vga_mon_pkg.sv
// Shared definitions for the VGA/HDMI frame monitor: FSM encoding, 720p
// geometry defaults and the per-pixel checksum step.
package vga_mon_pkg;

  typedef enum logic {
    WAIT_SYNC = 1'b0,
    IN_FRAME  = 1'b1
  } mon_state_e;

  localparam int unsigned H_ACTIVE_720P = 1280;
  localparam int unsigned V_ACTIVE_720P = 720;

  // Rotate-left by one, then fold the 12-bit pixel into the low bits.
  function automatic logic [31:0] chk_next(input logic [31:0] chk,
                                           input logic [11:0] pix12);
    return {chk[30:0], chk[31]} ^ {20'd0, pix12};
  endfunction

endpackage

// File: rtl/vga_sat_counter.sv
// Saturating up-counter with synchronous clear; clear+increment loads one.
module vga_sat_counter
  import vga_mon_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o,
  output logic [W-1:0] cnt_inc_o
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] cnt_q, cnt_d;

  assign cnt_o     = cnt_q;
  assign cnt_inc_o = (cnt_q == '1) ? cnt_q : cnt_q + ONE;

  always_comb begin
    // NOTE: every path assigns cnt_d (default first), so no latch is inferred.
    cnt_d = cnt_q;
    if (clr_i)      cnt_d = inc_i ? ONE : '0;
    else if (inc_i) cnt_d = cnt_inc_o;
  end

  always_ff @(posedge clk_i) begin
    // NOTE: state is updated with non-blocking assignments only, so every
    // flop samples pre-edge values regardless of process ordering.
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/vga_frame_monitor.sv
// Frame geometry and checksum monitor for a VGA/HDMI pixel stream; flags
// lines and frames whose size differs from the expected active geometry.
module vga_frame_monitor
  import vga_mon_pkg::*;
#(
  parameter int unsigned H_ACTIVE          = H_ACTIVE_720P,
  parameter int unsigned V_ACTIVE          = V_ACTIVE_720P,
  parameter bit          VSYNC_ACTIVE_HIGH = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        hsync_i,
  input  logic        vsync_i,
  input  logic        active_i,
  input  logic [3:0]  red_i,
  input  logic [3:0]  green_i,
  input  logic [3:0]  blue_i,
  output logic        frame_done_o,
  output logic [15:0] frame_count_o,
  output logic [15:0] pixels_per_line_o,
  output logic [15:0] lines_per_frame_o,
  output logic [31:0] frame_checksum_o,
  output logic        line_err_o,
  output logic        frame_err_o
);

  localparam logic [15:0] H_EXP = 16'(H_ACTIVE);
  localparam logic [15:0] V_EXP = 16'(V_ACTIVE);

  mon_state_e  state_q, state_d;
  logic        vs, vs_q, active_q;
  logic        fse, lee, in_frame, take_pix;
  logic        pix_clr, pix_inc, line_clr, line_inc;
  logic [15:0] pix_cnt, line_cnt, line_cnt_inc, lines_closed;
  logic [15:0] unused_pix_cnt_inc;
  logic [31:0] chk_q, chk_d, chk_base;
  logic [11:0] pix12;

  logic        frame_done_q, frame_done_d;
  logic [15:0] frame_count_q, frame_count_d;
  logic [15:0] ppl_q, ppl_d;
  logic [15:0] lpf_q, lpf_d;
  logic [31:0] fchk_q, fchk_d;
  logic        line_err_q, line_err_d;
  logic        frame_err_q, frame_err_d;

  logic unused_hsync;
  assign unused_hsync = hsync_i;

  assign vs    = ~(vsync_i ^ VSYNC_ACTIVE_HIGH);
  assign pix12 = {red_i, green_i, blue_i};

  assign fse      = vs & ~vs_q;
  assign lee      = ~active_i & active_q;
  assign in_frame = (state_q == IN_FRAME);
  // A pixel arriving with the frame-start event already belongs to the new frame.
  assign take_pix = active_i & (in_frame | fse);

  assign pix_clr  = (fse & ~in_frame) | (lee & in_frame);
  assign pix_inc  = take_pix;
  assign line_clr = fse;
  assign line_inc = lee & in_frame & ~fse;

  vga_sat_counter #(.W(16)) u_pix_cnt (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (pix_clr),
    .inc_i     (pix_inc),
    .cnt_o     (pix_cnt),
    .cnt_inc_o (unused_pix_cnt_inc)
  );

  vga_sat_counter #(.W(16)) u_line_cnt (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (line_clr),
    .inc_i     (line_inc),
    .cnt_o     (line_cnt),
    .cnt_inc_o (line_cnt_inc)
  );

  // A line ending on the same cycle as frame start is counted into the closing frame.
  assign lines_closed = lee ? line_cnt_inc : line_cnt;

  always_comb begin
    state_d       = state_q;
    frame_done_d  = 1'b0;
    frame_count_d = frame_count_q;
    ppl_d         = ppl_q;
    lpf_d         = lpf_q;
    fchk_d        = fchk_q;
    line_err_d    = line_err_q;
    frame_err_d   = frame_err_q;

    chk_base = fse ? 32'd0 : chk_q;
    chk_d    = take_pix ? chk_next(chk_base, pix12) : chk_base;

    if (fse) state_d = IN_FRAME;

    if (in_frame && lee) begin
      ppl_d = pix_cnt;
      if (pix_cnt != H_EXP) line_err_d = 1'b1;
    end

    if (in_frame && fse) begin
      lpf_d         = lines_closed;
      fchk_d        = chk_q;
      frame_count_d = frame_count_q + 16'd1;
      frame_done_d  = 1'b1;
      if (lines_closed != V_EXP) frame_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= WAIT_SYNC;
      vs_q          <= 1'b0;
      active_q      <= 1'b0;
      chk_q         <= '0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
      ppl_q         <= '0;
      lpf_q         <= '0;
      fchk_q        <= '0;
      line_err_q    <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      vs_q          <= vs;
      active_q      <= active_i;
      chk_q         <= chk_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
      ppl_q         <= ppl_d;
      lpf_q         <= lpf_d;
      fchk_q        <= fchk_d;
      line_err_q    <= line_err_d;
      frame_err_q   <= frame_err_d;
    end
  end

  assign frame_done_o      = frame_done_q;
  assign frame_count_o     = frame_count_q;
  assign pixels_per_line_o = ppl_q;
  assign lines_per_frame_o = lpf_q;
  assign frame_checksum_o  = fchk_q;
  assign line_err_o        = line_err_q;
  assign frame_err_o       = frame_err_q;

endmodule

// File: tb/tb_vga_frame_monitor.sv
// Self-checking bench for vga_frame_monitor: directed 4x3 frames plus random
// streams, compared every cycle against an event-level model of the monitor.
module tb_vga_frame_monitor;

  localparam int H = 4;
  localparam int V = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hsync = 1'b0, vsync = 1'b0, active = 1'b0;
  logic [3:0]  red = '0, green = '0, blue = '0;
  logic        frame_done;
  logic [15:0] frame_count, ppl, lpf;
  logic [31:0] fchk;
  logic        line_err, frame_err;

  vga_frame_monitor #(.H_ACTIVE(H), .V_ACTIVE(V), .VSYNC_ACTIVE_HIGH(1'b1)) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .hsync_i           (hsync),
    .vsync_i           (vsync),
    .active_i          (active),
    .red_i             (red),
    .green_i           (green),
    .blue_i            (blue),
    .frame_done_o      (frame_done),
    .frame_count_o     (frame_count),
    .pixels_per_line_o (ppl),
    .lines_per_frame_o (lpf),
    .frame_checksum_o  (fchk),
    .line_err_o        (line_err),
    .frame_err_o       (frame_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int done_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: tracks frames as pixel lists and line totals.
  bit          m_live = 1'b0;
  bit          m_in_frame = 1'b0, m_prev_vs = 1'b0, m_prev_act = 1'b0;
  int          m_pix = 0, m_lines = 0;
  logic [11:0] m_q[$];
  logic        e_done = 1'b0, e_lerr = 1'b0, e_ferr = 1'b0;
  logic [15:0] e_count = '0, e_ppl = '0, e_lpf = '0;
  logic [31:0] e_chk = '0;

  function automatic logic [15:0] sat16(input int v);
    return (v > 65535) ? 16'hFFFF : 16'(v);
  endfunction

  function automatic logic [31:0] fold_checksum();
    logic [31:0] c = '0;
    foreach (m_q[i]) c = {c[30:0], c[31]} ^ {20'd0, m_q[i]};
    return c;
  endfunction

  always @(posedge clk) begin : model
    bit vs_n, fse, lee, was_in;
    vs_n = (vsync === 1'b1);
    fse  = vs_n && !m_prev_vs;
    lee  = (active !== 1'b1) && m_prev_act;
    e_done = 1'b0;
    if (rst) begin
      m_in_frame = 0; m_prev_vs = 0; m_prev_act = 0;
      m_pix = 0; m_lines = 0; m_q.delete();
      e_count = '0; e_ppl = '0; e_lpf = '0; e_chk = '0;
      e_lerr = 1'b0; e_ferr = 1'b0;
    end else begin
      was_in = m_in_frame;
      if (was_in && lee) begin
        e_ppl = sat16(m_pix);
        if (m_pix != H) e_lerr = 1'b1;
        m_lines++;
        m_pix = 0;
      end
      if (fse) begin
        if (was_in) begin
          e_lpf = sat16(m_lines);
          e_chk = fold_checksum();
          if (m_lines != V) e_ferr = 1'b1;
          e_count = e_count + 16'd1;
          e_done = 1'b1;
        end else begin
          m_pix = 0;
        end
        m_in_frame = 1;
        m_lines = 0;
        m_q.delete();
      end
      if (m_in_frame && active === 1'b1) begin
        m_q.push_back({red, green, blue});
        m_pix++;
      end
      m_prev_vs  = vs_n;
      m_prev_act = (active === 1'b1);
    end
    m_live = 1'b1;
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("frame_done", 32'(frame_done), 32'(e_done));
      check("frame_count", 32'(frame_count), 32'(e_count));
      check("pixels_per_line", 32'(ppl), 32'(e_ppl));
      check("lines_per_frame", 32'(lpf), 32'(e_lpf));
      check("frame_checksum", fchk, e_chk);
      check("line_err", 32'(line_err), 32'(e_lerr));
      check("frame_err", 32'(frame_err), 32'(e_ferr));
      if (frame_done === 1'b1) done_seen++;
    end
  end

  task automatic drive(input bit vs, input bit act, input logic [11:0] px);
    @(negedge clk);
    vsync  = vs;
    active = act;
    {red, green, blue} = px;
    hsync  = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 12'h000);
  endtask

  task automatic vs_pulse(input bit act_first, input logic [11:0] px);
    drive(1'b1, act_first, px);
    drive(1'b1, 1'b0, 12'h000);
    drive(1'b0, 1'b0, 12'h000);
  endtask

  task automatic send_line(input int n, input bit rnd, input int gap);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b1, rnd ? 12'($urandom) : 12'h001);
    idle(gap);
  endtask

  task automatic clean_frame();
    for (int i = 0; i < V; i++) send_line(H, 1'b0, 2);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_done"}, 32'(frame_done), 32'd0);
    check({tag, "_count"}, 32'(frame_count), 32'd0);
    check({tag, "_ppl"}, 32'(ppl), 32'd0);
    check({tag, "_lpf"}, 32'(lpf), 32'd0);
    check({tag, "_chk"}, fchk, 32'd0);
    check({tag, "_lerr"}, 32'(line_err), 32'd0);
    check({tag, "_ferr"}, 32'(frame_err), 32'd0);
  endtask

  initial begin
    int d0;

    // Reset with vsync toggling.
    rst = 1'b1;
    for (int i = 0; i < 3; i++) drive(1'(i % 2), 1'b0, 12'h000);
    drive(1'b0, 1'b0, 12'h000);
    check_all_zero("reset");
    rst = 1'b0;
    idle(2);

    // Clean 4x3 frames with pixel 12'h001.
    d0 = done_seen;
    vs_pulse(1'b0, 12'h000);
    check("first_vsync_no_pulse", 32'(done_seen), 32'(d0));
    clean_frame();
    vs_pulse(1'b0, 12'h000);
    check("clean1_pulses", 32'(done_seen), 32'(d0 + 1));
    check("clean1_lpf", 32'(lpf), 32'd3);
    check("clean1_ppl", 32'(ppl), 32'd4);
    check("clean1_chk", fchk, 32'h0000_0FFF);
    clean_frame();
    vs_pulse(1'b0, 12'h000);
    check("clean2_pulses", 32'(done_seen), 32'(d0 + 2));
    check("clean2_count", 32'(frame_count), 32'd2);
    check("clean2_chk", fchk, 32'h0000_0FFF);
    check("clean2_lerr", 32'(line_err), 32'd0);
    check("clean2_ferr", 32'(frame_err), 32'd0);

    // Short line inside an otherwise correct frame.
    send_line(4, 1'b0, 2);
    send_line(3, 1'b0, 2);
    check("short_lerr_set", 32'(line_err), 32'd1);
    check("short_ppl", 32'(ppl), 32'd3);
    send_line(4, 1'b0, 2);
    vs_pulse(1'b0, 12'h000);
    check("short_lerr_sticky", 32'(line_err), 32'd1);
    check("short_ferr", 32'(frame_err), 32'd0);
    check("short_lpf", 32'(lpf), 32'd3);

    // Extra line.
    for (int i = 0; i < 4; i++) send_line(4, 1'b0, 2);
    vs_pulse(1'b0, 12'h000);
    check("extra_lpf", 32'(lpf), 32'd4);
    check("extra_ferr", 32'(frame_err), 32'd1);

    // Line end coincident with frame start.
    send_line(4, 1'b0, 2);
    send_line(4, 1'b0, 2);
    send_line(4, 1'b0, 0);
    vs_pulse(1'b0, 12'h000);
    check("coinc_lpf", 32'(lpf), 32'd3);
    clean_frame();
    vs_pulse(1'b0, 12'h000);
    check("coinc_next_lpf", 32'(lpf), 32'd3);

    // Mid-frame reset, then two clean frames (the second left open).
    vs_pulse(1'b0, 12'h000);
    send_line(4, 1'b0, 2);
    send_line(4, 1'b0, 2);
    rst = 1'b1;
    idle(2);
    check_all_zero("midrst");
    rst = 1'b0;
    d0 = done_seen;
    vs_pulse(1'b0, 12'h000);
    clean_frame();
    vs_pulse(1'b0, 12'h000);
    clean_frame();
    idle(2);
    check("midrst_pulses", 32'(done_seen), 32'(d0 + 1));
    check("midrst_count", 32'(frame_count), 32'd1);
    check("midrst_lpf", 32'(lpf), 32'd3);
    check("midrst_ppl", 32'(ppl), 32'd4);
    check("midrst_chk", fchk, 32'h0000_0FFF);
    check("midrst_lerr", 32'(line_err), 32'd0);
    check("midrst_ferr", 32'(frame_err), 32'd0);

    // Random streams: irregular lines, pixels on frame start, coincident events, resets.
    for (int f = 0; f < 60; f++) begin
      int nl;
      vs_pulse(1'($urandom_range(0, 3) == 0), 12'($urandom));
      nl = $urandom_range(0, 5);
      for (int l = 0; l < nl; l++)
        send_line($urandom_range(1, 6), 1'b1, $urandom_range(0, 2));
      if ($urandom_range(0, 14) == 0) begin
        rst = 1'b1;
        idle($urandom_range(1, 2));
        rst = 1'b0;
      end
    end
    vs_pulse(1'b0, 12'h000);
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
